// File: rtl/basic_uart_rx.sv
// rtl/basic_uart_rx.sv - 8N1 UART receiver with mid-bit sampling and per-frame strobes
// Optional even parity stage enabled by defining UART_RX_PARITY_EN.
module basic_uart_rx #(
    parameter int SYSCLK    = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int BAUD_DIV  = SYSCLK / BAUD_RATE,
    parameter int N         = 9
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iUart_rx,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrame_err,
    output logic       oParity_err,
    output logic       oBusy
);

    localparam logic [N-1:0] HALF_TICK = N'((BAUD_DIV >> 1) - 1);
    localparam logic [N-1:0] FULL_TICK = N'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic         rx_meta_q, rx_s_q;
    logic [N-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   data_q, data_d;
    logic         valid_q, valid_d;
    logic         ferr_q, ferr_d;
    logic         half_tick, full_tick, stop_sample;
`ifdef UART_RX_PARITY_EN
    logic         par_q, par_d;
    logic         perr_q, perr_d;
`endif

    assign half_tick   = (cnt_q == HALF_TICK);
    assign full_tick   = (cnt_q == FULL_TICK);
    assign stop_sample = (state_q == S_STOP) && full_tick;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= iUart_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!rx_s_q) state_d = S_START;
            S_START: if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA: begin
                if (full_tick && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (full_tick) state_d = S_STOP;
`endif
            S_STOP:  if (full_tick) state_d = rx_s_q ? S_IDLE : S_BREAK;
            // A held-low line parks here so it cannot be mistaken for new start bits
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_q == S_IDLE || (state_q == S_DATA && full_tick))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;

        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (state_q == S_START) begin
            bit_idx_d = '0;
        end else if (state_q == S_DATA && full_tick) begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {rx_s_q, shift_q[7:1]};
        end
    end

    always_comb begin
        ferr_d = stop_sample && !rx_s_q;
`ifdef UART_RX_PARITY_EN
        par_d = par_q;
        if (state_q == S_START)
            par_d = 1'b0;
        else if ((state_q == S_DATA || state_q == S_PARITY) && full_tick)
            par_d = par_q ^ rx_s_q;
        valid_d = stop_sample && rx_s_q && !par_q;
        perr_d  = stop_sample && rx_s_q && par_q;
`else
        valid_d = stop_sample && rx_s_q;
`endif
        data_d = valid_d ? shift_q : data_q;
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oFrame_err = ferr_q;
    assign oBusy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign oParity_err = perr_q;
`else
    assign oParity_err = 1'b0;
`endif

endmodule

// File: tb/tb_basic_uart_rx.sv
// tb/tb_basic_uart_rx.sv - directed vector bench for basic_uart_rx
module tb_basic_uart_rx;

    logic       iClk;
    logic       iRst_n;
    logic       iUart_rx;
    logic [7:0] oData;
    logic       oValid, oFrame_err, oParity_err, oBusy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid, n_ferr, n_perr, busy_cycles;
    logic [7:0] cap[$];

    basic_uart_rx dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iUart_rx   (iUart_rx),
        .oData      (oData),
        .oValid     (oValid),
        .oFrame_err (oFrame_err),
        .oParity_err(oParity_err),
        .oBusy      (oBusy)
    );

    initial iClk = 1'b0;
    always #10 iClk = ~iClk;

    always @(negedge iClk) begin
        if (oValid) begin
            n_valid++;
            cap.push_back(oData);
        end
        if (oFrame_err) n_ferr++;
        if (oParity_err) n_perr++;
        if (oBusy) busy_cycles++;
    end

    typedef struct {
        logic [7:0] data;
        int         cpb;
        logic       stop_bit;
        logic       par_flip;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_valid = 0;
        n_ferr = 0;
        n_perr = 0;
        busy_cycles = 0;
        cap.delete();
    endtask

    task automatic send_bit(input logic b, input int cpb);
        iUart_rx = b;
        repeat (cpb) @(negedge iClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int cpb, input logic stop_bit,
                              input logic par_flip);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, cpb);
`endif
        send_bit(stop_bit, cpb);
    endtask

    initial begin
        vecs.push_back('{8'h41, 434, 1'b1, 1'b0, 1, 0, 0, 8'h41});
        vecs.push_back('{8'hC5, 425, 1'b1, 1'b0, 1, 0, 0, 8'hC5});
        vecs.push_back('{8'hC5, 443, 1'b1, 1'b0, 1, 0, 0, 8'hC5});
        vecs.push_back('{8'h55, 434, 1'b0, 1'b0, 0, 1, 0, 8'hC5});
        vecs.push_back('{8'h5A, 434, 1'b1, 1'b0, 1, 0, 0, 8'h5A});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h41, 434, 1'b1, 1'b0, 1, 0, 0, 8'h41});
        vecs.push_back('{8'h41, 434, 1'b1, 1'b1, 0, 0, 1, 8'h41});
`endif

        iUart_rx = 1'b1;
        iRst_n   = 1'b0;
        clr();
        repeat (5) @(negedge iClk);
        chk("reset_data", oData, 8'h00);
        chk("reset_valid", oValid, 0);
        chk("reset_ferr", oFrame_err, 0);
        chk("reset_perr", oParity_err, 0);
        chk("reset_busy", oBusy, 0);
        iRst_n = 1'b1;
        repeat (20) @(negedge iClk);

        foreach (vecs[k]) begin
            clr();
            send_frame(vecs[k].data, vecs[k].cpb, vecs[k].stop_bit, vecs[k].par_flip);
            if (!vecs[k].stop_bit) send_bit(1'b0, 20 * vecs[k].cpb);
            send_bit(1'b1, 2 * vecs[k].cpb);
            chk($sformatf("vec%0d_valid", k), n_valid, vecs[k].exp_valid);
            chk($sformatf("vec%0d_ferr", k), n_ferr, vecs[k].exp_ferr);
            chk($sformatf("vec%0d_perr", k), n_perr, vecs[k].exp_perr);
            chk($sformatf("vec%0d_data", k), oData, vecs[k].exp_data);
            chk($sformatf("vec%0d_busy", k), oBusy, 0);
        end

        clr();
        send_frame(8'h00, 434, 1'b1, 1'b0);
        send_frame(8'hFF, 434, 1'b1, 1'b0);
        send_bit(1'b1, 2 * 434);
        chk("b2b_valid_count", n_valid, 2);
        chk("b2b_first", (cap.size() > 0) ? int'(cap[0]) : -1, 8'h00);
        chk("b2b_second", (cap.size() > 1) ? int'(cap[1]) : -1, 8'hFF);
        chk("b2b_errs", n_ferr + n_perr, 0);

        clr();
        send_bit(1'b0, 100);
        send_bit(1'b1, 2 * 434);
        chk("glitch_strobes", n_valid + n_ferr + n_perr, 0);
        chk("glitch_busy_window", int'(busy_cycles >= 210 && busy_cycles <= 225), 1);
        chk("glitch_idle", oBusy, 0);

        clr();
        send_bit(1'b0, 434);
        for (int i = 0; i < 3; i++) send_bit(((8'hA3 >> i) & 8'h01) != 0, 434);
        send_bit(1'b0, 200);
        iRst_n   = 1'b0;
        iUart_rx = 1'b1;
        repeat (3) @(negedge iClk);
        chk("midrst_data", oData, 8'h00);
        chk("midrst_busy", oBusy, 0);
        iRst_n = 1'b1;
        send_bit(1'b1, 2 * 434);
        chk("midrst_no_strobe", n_valid + n_ferr + n_perr, 0);
        send_frame(8'h3C, 434, 1'b1, 1'b0);
        send_bit(1'b1, 2 * 434);
        chk("after_rst_valid", n_valid, 1);
        chk("after_rst_data", oData, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
